// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master system bus arbiter.
// Owner state encoding, burst defaults and device-select codes.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StOwn0 = 2'd1,
      StOwn1 = 2'd2
   } owner_state_e;

   localparam int unsigned MAX_BURST_DEFAULT = 8;
   localparam int unsigned BURST_CNT_W       = 8;

   localparam logic DEV_MEM = 1'b0;
   localparam logic DEV_IO  = 1'b1;

   // Maps a master index to its ownership state.
   function automatic owner_state_e own_state(input logic idx);
      return idx ? StOwn1 : StOwn0;
   endfunction

endpackage

// File: rtl/bus_master_mux.sv
// Request/response steering between the two masters and the system bus.
// Purely combinational; selection comes from the registered owner state.
module bus_master_mux
   import bus_arbiter_pkg::*;
(
   input  logic [1:0]  owner_state,

   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [2:0]  m0_read_type,
   input  logic        m0_device_id,
   input  logic [31:0] m0_wdata,
   input  logic        m0_we,
   output logic        m0_gnt,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [2:0]  m1_read_type,
   input  logic        m1_device_id,
   input  logic [31:0] m1_wdata,
   input  logic        m1_we,
   output logic        m1_gnt,
   output logic [31:0] m1_rdata,

   output logic [31:0] bus_addr,
   output logic [2:0]  bus_read_type,
   output logic        bus_device_id,
   output logic [31:0] bus_wdata,
   output logic        bus_we,
   input  logic [31:0] bus_rdata
);

   owner_state_e sel;
   assign sel = owner_state_e'(owner_state);

   always_comb begin
      m0_gnt        = 1'b0;
      m1_gnt        = 1'b0;
      m0_rdata      = '0;
      m1_rdata      = '0;
      bus_addr      = '0;
      bus_read_type = '0;
      bus_device_id = DEV_MEM;
      bus_wdata     = '0;
      bus_we        = 1'b0;
      unique case (sel)
         StOwn0: begin
            m0_gnt        = 1'b1;
            m0_rdata      = bus_rdata;
            bus_addr      = m0_addr;
            bus_read_type = m0_read_type;
            bus_device_id = m0_device_id;
            bus_wdata     = m0_wdata;
            // A write needs request and grant together, never the grant alone.
            bus_we        = m0_we & m0_req & m0_gnt;
         end
         StOwn1: begin
            m1_gnt        = 1'b1;
            m1_rdata      = bus_rdata;
            bus_addr      = m1_addr;
            bus_read_type = m1_read_type;
            bus_device_id = m1_device_id;
            bus_wdata     = m1_wdata;
            bus_we        = m1_we & m1_req & m1_gnt;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with bounded burst tenure.
// Owner FSM and burst counter live here; steering lives in bus_master_mux.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   input  logic [2:0]  m0_read_type,
   input  logic        m0_device_id,
   input  logic [31:0] m0_wdata,
   input  logic        m0_we,
   output logic        m0_gnt,
   output logic [31:0] m0_rdata,

   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic [2:0]  m1_read_type,
   input  logic        m1_device_id,
   input  logic [31:0] m1_wdata,
   input  logic        m1_we,
   output logic        m1_gnt,
   output logic [31:0] m1_rdata,

   output logic [31:0] bus_addr,
   output logic [2:0]  bus_read_type,
   output logic        bus_device_id,
   output logic [31:0] bus_wdata,
   output logic        bus_we,
   input  logic [31:0] bus_rdata
);

   localparam logic [BURST_CNT_W-1:0] BurstLast = BURST_CNT_W'(MAX_BURST - 1);

   owner_state_e           state_q, state_d;
   logic                   last_owner_q, last_owner_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic                   owner_req;
   logic                   burst_full;

   assign burst_full = (burst_cnt_q == BurstLast);
   assign owner_req  = ((state_q == StOwn0) && m0_req) || ((state_q == StOwn1) && m1_req);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (m0_req && m1_req) begin
               state_d = own_state(~last_owner_q);
            end else if (m0_req) begin
               state_d = StOwn0;
            end else if (m1_req) begin
               state_d = StOwn1;
            end
         end
         StOwn0: begin
            if (m0_req) begin
               if (m1_req && burst_full) state_d = StOwn1;
            end else begin
               state_d = m1_req ? StOwn1 : StIdle;
            end
         end
         StOwn1: begin
            if (m1_req) begin
               if (m0_req && burst_full) state_d = StOwn0;
            end else begin
               state_d = m0_req ? StOwn0 : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Counter restarts on any ownership change, including a drop to idle.
   always_comb begin
      burst_cnt_d = burst_cnt_q;
      if (state_d != state_q) begin
         burst_cnt_d = '0;
      end else if (owner_req && !burst_full) begin
         burst_cnt_d = burst_cnt_q + 1'b1;
      end
   end

   always_comb begin
      last_owner_d = last_owner_q;
      if (state_d == StOwn0) begin
         last_owner_d = 1'b0;
      end else if (state_d == StOwn1) begin
         last_owner_d = 1'b1;
      end
   end

   // last_owner resets to 1 so the CPU wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_owner_q <= 1'b1;
         burst_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
      end
   end

   bus_master_mux u_mux (
      .owner_state   (state_q),
      .m0_req        (m0_req),
      .m0_addr       (m0_addr),
      .m0_read_type  (m0_read_type),
      .m0_device_id  (m0_device_id),
      .m0_wdata      (m0_wdata),
      .m0_we         (m0_we),
      .m0_gnt        (m0_gnt),
      .m0_rdata      (m0_rdata),
      .m1_req        (m1_req),
      .m1_addr       (m1_addr),
      .m1_read_type  (m1_read_type),
      .m1_device_id  (m1_device_id),
      .m1_wdata      (m1_wdata),
      .m1_we         (m1_we),
      .m1_gnt        (m1_gnt),
      .m1_rdata      (m1_rdata),
      .bus_addr      (bus_addr),
      .bus_read_type (bus_read_type),
      .bus_device_id (bus_device_id),
      .bus_wdata     (bus_wdata),
      .bus_we        (bus_we),
      .bus_rdata     (bus_rdata)
   );

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, latency, round-robin, burst limit,
// write isolation, asynchronous reset and read steering.
module tb_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_device_id, m0_we, m0_gnt;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [2:0]  m0_read_type;
   logic        m1_req, m1_device_id, m1_we, m1_gnt;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [2:0]  m1_read_type;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [2:0]  bus_read_type;
   logic        bus_device_id, bus_we;

   int total = 0;
   int bad   = 0;
   int acc0  = 0;
   int acc1  = 0;
   int base0, base1;
   logic count_en = 1'b0;

   always #5 clk = ~clk;

   bus_arbiter #(.MAX_BURST(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .m0_req        (m0_req),
      .m0_addr       (m0_addr),
      .m0_read_type  (m0_read_type),
      .m0_device_id  (m0_device_id),
      .m0_wdata      (m0_wdata),
      .m0_we         (m0_we),
      .m0_gnt        (m0_gnt),
      .m0_rdata      (m0_rdata),
      .m1_req        (m1_req),
      .m1_addr       (m1_addr),
      .m1_read_type  (m1_read_type),
      .m1_device_id  (m1_device_id),
      .m1_wdata      (m1_wdata),
      .m1_we         (m1_we),
      .m1_gnt        (m1_gnt),
      .m1_rdata      (m1_rdata),
      .bus_addr      (bus_addr),
      .bus_read_type (bus_read_type),
      .bus_device_id (bus_device_id),
      .bus_wdata     (bus_wdata),
      .bus_we        (bus_we),
      .bus_rdata     (bus_rdata)
   );

   // Inputs are stable at the falling edge, so req&gnt here is a completion
   // at the following rising edge.
   always @(negedge clk) begin
      if (count_en) begin
         if (m0_req && m0_gnt) acc0++;
         if (m1_req && m1_gnt) acc1++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      m0_req = 0; m0_addr = '0; m0_read_type = '0; m0_device_id = 0; m0_wdata = '0; m0_we = 0;
      m1_req = 0; m1_addr = '0; m1_read_type = '0; m1_device_id = 0; m1_wdata = '0; m1_we = 0;
      bus_rdata = 32'h1234_5678;

      // Reset state
      tick(); tick();
      chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("rst_bus_we", 32'(bus_we), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      rst_n = 1'b1;

      // Single request: one-cycle grant latency, bus follows m0
      tick();
      m0_req = 1; m0_addr = 32'h1000_0010; m0_read_type = 3'd2; m0_device_id = 1;
      #1;
      chk("lat_pre_gnt", 32'(m0_gnt), 32'd0);
      tick();
      chk("lat_m0_gnt", 32'(m0_gnt), 32'd1);
      chk("lat_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("lat_bus_addr", bus_addr, 32'h1000_0010);
      chk("lat_bus_rtype", 32'(bus_read_type), 32'd2);
      chk("lat_bus_dev", 32'(bus_device_id), 32'd1);
      m0_addr = 32'h2000_0040; bus_rdata = 32'hDEAD_BEEF;
      #1;
      chk("follow_bus_addr", bus_addr, 32'h2000_0040);
      chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("rd_m1_rdata", m1_rdata, 32'd0);
      tick();
      chk("hold_m0_gnt", 32'(m0_gnt), 32'd1);
      m0_req = 0;
      tick();
      chk("idle_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("idle_bus_addr", bus_addr, 32'd0);

      // Tie after reset goes to m0, then handoff to m1 without an idle bubble
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      m0_req = 1; m1_req = 1; m1_addr = 32'h3000_0000;
      tick();
      chk("tie_m0_gnt", 32'(m0_gnt), 32'd1);
      chk("tie_m1_gnt", 32'(m1_gnt), 32'd0);
      m0_req = 0;
      tick();
      chk("hand_m1_gnt", 32'(m1_gnt), 32'd1);
      chk("hand_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("hand_bus_addr", bus_addr, 32'h3000_0000);

      // Both hold requests: 8-cycle tenures alternate
      m0_req = 1;
      base0 = acc0; base1 = acc1;
      count_en = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("burst1_m1_gnt", 32'(m1_gnt), 32'd1);
      end
      tick();
      chk("burst1_switch_m0", 32'(m0_gnt), 32'd1);
      chk("burst1_acc1", 32'(acc1 - base1), 32'd8);
      chk("burst1_acc0", 32'(acc0 - base0), 32'd0);
      for (int i = 0; i < 7; i++) tick();
      chk("burst2_m0_last", 32'(m0_gnt), 32'd1);
      tick();
      chk("burst2_switch_m1", 32'(m1_gnt), 32'd1);
      chk("burst2_acc0", 32'(acc0 - base0), 32'd8);
      count_en = 1'b0;

      // m1 owns and writes while m0 waits with its own write pending
      m1_we = 1; m1_wdata = 32'hA5A5_0001;
      m0_we = 1; m0_wdata = 32'h0BAD_0000;
      #1;
      chk("wr_bus_we", 32'(bus_we), 32'd1);
      chk("wr_bus_wdata", bus_wdata, 32'hA5A5_0001);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wr_iso_wdata", bus_wdata, 32'hA5A5_0001);
      end

      // Asynchronous reset mid-burst
      rst_n = 1'b0;
      #1;
      chk("arst_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("arst_bus_we", 32'(bus_we), 32'd0);
      chk("arst_bus_wdata", bus_wdata, 32'd0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("arst_rel_m0_gnt", 32'(m0_gnt), 32'd0);
      tick();
      chk("arst_tie_m0_gnt", 32'(m0_gnt), 32'd1);
      chk("arst_tie_m1_gnt", 32'(m1_gnt), 32'd0);
      chk("arst_m0_write", bus_wdata, 32'h0BAD_0000);

      // Sole requester keeps the bus past the burst limit
      m1_req = 0;
      for (int i = 0; i < 12; i++) tick();
      chk("retain_m0_gnt", 32'(m0_gnt), 32'd1);
      m0_req = 0;
      tick();
      chk("end_m0_gnt", 32'(m0_gnt), 32'd0);
      chk("end_bus_we", 32'(bus_we), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8, is the maximum number of consecutive granted cycles an owner keeps while the other master waits; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 mN_req  input  1  master N (N=0 CPU, N=1 DMA) requests the system bus.
REQ-005 mN_addr / mN_read_type / mN_device_id  input  32/3/1  master N access address, load type and device select (0 memory, 1 IO).
REQ-006 mN_wdata / mN_we  input  32/1  master N write data and write enable.
REQ-007 mN_gnt  output  1  master N owns the bus this cycle.
REQ-008 mN_rdata  output  32  read data returned to master N.
REQ-009 bus_addr / bus_read_type / bus_device_id / bus_wdata / bus_we  output  32/3/1/32/1  request driven onto the system bus.
REQ-010 bus_rdata  input  32  combinational read data from the system bus.

Function
REQ-011 Registered state: owner FSM {IDLE, OWN0, OWN1}, last_owner (1 bit), burst_cnt (8 bits).
REQ-012 mN_gnt SHALL be 1 exactly when the state is OWNN; the grant is decoded from registered state only.
REQ-013 In IDLE with exactly one mN_req high, the next state SHALL be OWNN; grant latency from request is 1 cycle.
REQ-014 In IDLE with both requests high, the next state SHALL grant the master that is not last_owner (round-robin).
REQ-015 In OWNN with mN_req low and the other request high, the next state SHALL be the other OWN state directly, with no IDLE bubble.
REQ-016 In OWNN with mN_req low and the other request low, the next state SHALL be IDLE.
REQ-017 burst_cnt SHALL load 0 on every grant change and increment each cycle in OWNN while mN_req is high, saturating at MAX_BURST-1.
REQ-018 In OWNN with mN_req high, burst_cnt equal to MAX_BURST-1 and the other request high, the next state SHALL be the other OWN state (forced handoff).
REQ-019 In OWNN with mN_req high and the other request low, ownership SHALL be retained indefinitely.
REQ-020 last_owner SHALL update to N on every entry into OWNN.
REQ-021 When owner N exists, bus_addr, bus_read_type, bus_device_id and bus_wdata SHALL equal master N's inputs; in IDLE they SHALL be 0.
REQ-022 bus_we SHALL equal mN_we AND mN_req AND mN_gnt for the owner N, and 0 in IDLE; a write is never issued without both request and grant.
REQ-023 mN_rdata SHALL equal bus_rdata when mN_gnt=1, else 0.
REQ-024 An access by master N is complete on each clock edge where mN_req and mN_gnt are both 1; a master holds its inputs stable while mN_req=1 and mN_gnt=0.

Reset
REQ-025 While rst_n=0: state IDLE, last_owner=1 (CPU wins the first tie), burst_cnt=0, both grants 0, bus_we=0, bus outputs 0.
REQ-026 Assertion of rst_n mid-burst SHALL drop the grant and bus_we immediately, without waiting for a clock edge.
REQ-027 After rst_n deasserts, arbitration SHALL resume from IDLE on the first rising edge.

Structure
REQ-028 A shared package SHALL hold the owner-state enum, the MAX_BURST default and the device-id constants (DEV_MEM=0, DEV_IO=1).
REQ-029 The request/response multiplexing SHALL sit in one sub-module, bus_master_mux, selected by the registered owner; the FSM and counter stay in bus_arbiter.

Verification
REQ-030 Reset, then m0_req=1 only: m0_gnt=1 on the 2nd edge; bus_addr follows m0_addr; m1_gnt stays 0.
REQ-031 From IDLE, both requests raised in the same cycle after reset: m0 granted first; after m0 drops req, m1 is granted on the next edge with no IDLE cycle.
REQ-032 Both masters hold req continuously, MAX_BURST=8: grants alternate every 8 cycles; each master logs exactly 8 completed accesses per tenure.
REQ-033 m1 owns the bus, m1_we=1, m0_we=1 while waiting: bus_we and bus_wdata reflect m1 only; no m0 write reaches the bus until m0_gnt=1.
REQ-034 rst_n pulsed low mid-burst while m1 writes: m1_gnt and bus_we go to 0 asynchronously; after release, the first tie grants m0.
REQ-035 Read with m0 owner and bus_rdata=0xDEADBEEF: m0_rdata=0xDEADBEEF and m1_rdata=0.
